// File: rtl/clock_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_mode_ctrl_if
// Description : Key inputs and display/unit control outputs of the front-panel
//               sequencer, bundled for connection between panel and units.
// Revision    : 1.0  initial release
// ============================================================================
interface clock_mode_ctrl_if;
  logic       tick_1ms;
  logic       key_mode;
  logic       key_sel;
  logic       key_inc;
  logic [1:0] mode;
  logic [1:0] edit_field;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic       sw_run;
  logic       sw_clr;
  logic       blank;

  modport master (
    output tick_1ms, key_mode, key_sel, key_inc,
    input  mode, edit_field, inc_hour, inc_min, inc_sec, sw_run, sw_clr, blank
  );

  modport slave (
    input  tick_1ms, key_mode, key_sel, key_inc,
    output mode, edit_field, inc_hour, inc_min, inc_sec, sw_run, sw_clr, blank
  );
endinterface
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_mode_ctrl
// Description : Front-panel sequencer. Turns three active-low keys into display
//               mode, edit-field selection, increment strobes with auto-repeat,
//               stopwatch run/clear and a blink enable for edited digits.
// Revision    : 1.0  initial release
// ============================================================================
module clock_mode_ctrl #(
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned BLINK_MS        = 250,
  parameter int unsigned EDIT_TIMEOUT_MS = 10000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  clock_mode_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    TIME_RUN   = 3'd0,
    TIME_EDIT  = 3'd1,
    ALARM_VIEW = 3'd2,
    ALARM_EDIT = 3'd3,
    WATCH      = 3'd4
  } state_t;

  localparam logic [1:0]  c_F_NONE  = 2'b00;
  localparam logic [1:0]  c_F_HOUR  = 2'b01;
  localparam logic [1:0]  c_F_MIN   = 2'b10;
  localparam logic [1:0]  c_F_SEC   = 2'b11;
  localparam logic [15:0] c_DELAY   = 16'(REPEAT_DELAY_MS);
  localparam logic [15:0] c_RATE    = 16'(REPEAT_RATE_MS);
  localparam logic [15:0] c_BLINK   = 16'(BLINK_MS);
  localparam logic [15:0] c_TIMEOUT = 16'(EDIT_TIMEOUT_MS);

  state_t      r_state, w_state_nx;
  logic [1:0]  r_field, w_field_nx;
  logic [1:0]  r_mode, w_mode_nx;
  logic        r_prev_mode, r_prev_sel, r_prev_inc, r_armed;
  logic        r_rep_act, w_rep_act_nx;
  logic        r_rep_phase, w_rep_phase_nx;
  logic [15:0] r_rep_cnt, w_rep_cnt_nx, w_rep_p1;
  logic [15:0] r_to_cnt, w_to_cnt_nx, w_to_p1;
  logic [15:0] r_blink_cnt, w_blink_cnt_nx, w_blink_p1;
  logic        r_blank, w_blank_nx;
  logic        r_sw_run, w_sw_run_nx;
  logic        r_sw_clr, w_sw_clr_nx;
  logic        r_inc_hour, r_inc_min, r_inc_sec;
  logic        w_strobe, w_rep_hit, w_in_edit, w_next_edit, w_restart;
  logic        w_ev_mode, w_ev_sel, w_ev_inc;

  // Previous-value registers reset high; r_armed keeps the first cycle after
  // reset a sample-only cycle so a key held through reset raises no event.
  assign w_ev_mode = r_armed & r_prev_mode & ~bus.key_mode;
  assign w_ev_sel  = r_armed & r_prev_sel  & ~bus.key_sel  & ~w_ev_mode;
  assign w_ev_inc  = r_armed & r_prev_inc  & ~bus.key_inc  & ~w_ev_mode & ~w_ev_sel;

  assign w_in_edit   = (r_state == TIME_EDIT) || (r_state == ALARM_EDIT);
  assign w_next_edit = (w_state_nx == TIME_EDIT) || (w_state_nx == ALARM_EDIT);

  assign w_rep_p1   = (r_rep_cnt   == 16'hFFFF) ? r_rep_cnt   : r_rep_cnt   + 16'd1;
  assign w_to_p1    = (r_to_cnt    == 16'hFFFF) ? r_to_cnt    : r_to_cnt    + 16'd1;
  assign w_blink_p1 = (r_blink_cnt == 16'hFFFF) ? r_blink_cnt : r_blink_cnt + 16'd1;

  // First repeat after the hold delay, later ones every repeat period.
  assign w_rep_hit = r_rep_phase ? (w_rep_p1 >= c_RATE) : (w_rep_p1 >= c_DELAY);

  assign w_mode_nx = ((w_state_nx == ALARM_VIEW) || (w_state_nx == ALARM_EDIT)) ? 2'b01 :
                     (w_state_nx == WATCH) ? 2'b10 : 2'b00;

  assign w_restart = (w_state_nx != r_state) || (w_field_nx != r_field) || w_strobe;

  // Next state, field, stopwatch controls, strobes, repeat and timeout counters.
  always_comb begin
    w_state_nx     = r_state;
    w_field_nx     = r_field;
    w_sw_run_nx    = r_sw_run;
    w_sw_clr_nx    = 1'b0;
    w_strobe       = 1'b0;
    w_rep_act_nx   = r_rep_act;
    w_rep_phase_nx = r_rep_phase;
    w_rep_cnt_nx   = r_rep_cnt;
    w_to_cnt_nx    = 16'd0;
    if (w_ev_mode) begin
      w_field_nx   = c_F_NONE;
      w_rep_act_nx = 1'b0;
      case (r_state)
        TIME_RUN:   w_state_nx = ALARM_VIEW;
        ALARM_VIEW: w_state_nx = WATCH;
        WATCH:      w_state_nx = TIME_RUN;
        TIME_EDIT:  w_state_nx = TIME_RUN;
        ALARM_EDIT: w_state_nx = ALARM_VIEW;
        default:    w_state_nx = TIME_RUN;
      endcase
    end else if (w_ev_sel) begin
      w_rep_act_nx = 1'b0;
      case (r_state)
        TIME_RUN: begin
          w_state_nx = TIME_EDIT;
          w_field_nx = c_F_HOUR;
        end
        ALARM_VIEW: begin
          w_state_nx = ALARM_EDIT;
          w_field_nx = c_F_HOUR;
        end
        TIME_EDIT: begin
          if (r_field == c_F_HOUR) begin
            w_field_nx = c_F_MIN;
          end else if (r_field == c_F_MIN) begin
            w_field_nx = c_F_SEC;
          end else begin
            w_state_nx = TIME_RUN;
            w_field_nx = c_F_NONE;
          end
        end
        ALARM_EDIT: begin
          if (r_field == c_F_HOUR) begin
            w_field_nx = c_F_MIN;
          end else begin
            w_state_nx = ALARM_VIEW;
            w_field_nx = c_F_NONE;
          end
        end
        WATCH: begin
          w_sw_clr_nx = 1'b1;
          w_sw_run_nx = 1'b0;
        end
        default: w_state_nx = TIME_RUN;
      endcase
    end else if (w_ev_inc) begin
      if (w_in_edit) begin
        w_strobe     = 1'b1;
        w_rep_act_nx = 1'b1;
      end else if (r_state == WATCH) begin
        w_sw_run_nx = ~r_sw_run;
      end
    end else begin
      if (r_rep_act && bus.key_inc) begin
        w_rep_act_nx = 1'b0;
      end else if (r_rep_act && bus.tick_1ms) begin
        if (w_rep_hit) begin
          w_strobe       = 1'b1;
          w_rep_phase_nx = 1'b1;
          w_rep_cnt_nx   = 16'd0;
        end else begin
          w_rep_cnt_nx = w_rep_p1;
        end
      end
      if (w_in_edit && !w_strobe) begin
        if (bus.tick_1ms && (w_to_p1 >= c_TIMEOUT)) begin
          w_state_nx   = (r_state == TIME_EDIT) ? TIME_RUN : ALARM_VIEW;
          w_field_nx   = c_F_NONE;
          w_rep_act_nx = 1'b0;
        end else if (bus.tick_1ms) begin
          w_to_cnt_nx = w_to_p1;
        end else begin
          w_to_cnt_nx = r_to_cnt;
        end
      end
    end
    if (!w_rep_act_nx || w_ev_inc) begin
      w_rep_cnt_nx   = 16'd0;
      w_rep_phase_nx = 1'b0;
    end
  end

  // Blink half-period counter; any visible edit activity shows the digits.
  always_comb begin
    w_blink_cnt_nx = r_blink_cnt;
    w_blank_nx     = r_blank;
    if (!w_next_edit || w_restart) begin
      w_blink_cnt_nx = 16'd0;
      w_blank_nx     = 1'b0;
    end else if (bus.tick_1ms) begin
      if (w_blink_p1 >= c_BLINK) begin
        w_blink_cnt_nx = 16'd0;
        w_blank_nx     = ~r_blank;
      end else begin
        w_blink_cnt_nx = w_blink_p1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= TIME_RUN;
      r_field     <= c_F_NONE;
      r_mode      <= 2'b00;
      r_prev_mode <= 1'b1;
      r_prev_sel  <= 1'b1;
      r_prev_inc  <= 1'b1;
      r_armed     <= 1'b0;
      r_rep_act   <= 1'b0;
      r_rep_phase <= 1'b0;
      r_rep_cnt   <= 16'd0;
      r_to_cnt    <= 16'd0;
      r_blink_cnt <= 16'd0;
      r_blank     <= 1'b0;
      r_sw_run    <= 1'b0;
      r_sw_clr    <= 1'b0;
      r_inc_hour  <= 1'b0;
      r_inc_min   <= 1'b0;
      r_inc_sec   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_field     <= w_field_nx;
      r_mode      <= w_mode_nx;
      r_prev_mode <= bus.key_mode;
      r_prev_sel  <= bus.key_sel;
      r_prev_inc  <= bus.key_inc;
      r_armed     <= 1'b1;
      r_rep_act   <= w_rep_act_nx;
      r_rep_phase <= w_rep_phase_nx;
      r_rep_cnt   <= w_rep_cnt_nx;
      r_to_cnt    <= w_to_cnt_nx;
      r_blink_cnt <= w_blink_cnt_nx;
      r_blank     <= w_blank_nx;
      r_sw_run    <= w_sw_run_nx;
      r_sw_clr    <= w_sw_clr_nx;
      r_inc_hour  <= w_strobe && (r_field == c_F_HOUR);
      r_inc_min   <= w_strobe && (r_field == c_F_MIN);
      r_inc_sec   <= w_strobe && (r_field == c_F_SEC);
    end
  end

  assign bus.mode       = r_mode;
  assign bus.edit_field = r_field;
  assign bus.inc_hour   = r_inc_hour;
  assign bus.inc_min    = r_inc_min;
  assign bus.inc_sec    = r_inc_sec;
  assign bus.sw_run     = r_sw_run;
  assign bus.sw_clr     = r_sw_clr;
  assign bus.blank      = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_mode_ctrl
// Description : Self-checking bench for clock_mode_ctrl with a behavioural
//               model of the panel sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_clock_mode_ctrl;

  localparam int DELAY   = 500;
  localparam int RATE    = 100;
  localparam int BLINK   = 250;
  localparam int TIMEOUT = 10000;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  clock_mode_ctrl_if bus();

  clock_mode_ctrl #(
    .REPEAT_DELAY_MS (DELAY),
    .REPEAT_RATE_MS  (RATE),
    .BLINK_MS        (BLINK),
    .EDIT_TIMEOUT_MS (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  // Behavioural model: mode 0/1/2, edit flag, field 0..3, elapsed-tick counts.
  int m_mode, m_field, m_held, m_idle, m_bt;
  bit m_edit, m_run, m_clr, m_blank, m_armed, m_pm, m_ps, m_pi;
  bit [2:0] m_inc;

  logic [9:0] w_dut;
  assign w_dut = {bus.mode, bus.edit_field, bus.inc_hour, bus.inc_min, bus.inc_sec,
                  bus.sw_run, bus.sw_clr, bus.blank};

  function automatic logic [9:0] exp_vec();
    return {2'(m_mode), 2'(m_field), m_inc, m_run, m_clr, m_blank};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_field = 0; m_held = -1; m_idle = 0; m_bt = 0;
    m_edit = 0; m_run = 0; m_clr = 0; m_blank = 0; m_inc = 3'b000;
    m_armed = 0; m_pm = 1; m_ps = 1; m_pi = 1;
  endtask

  task automatic model_step(input bit km, input bit ks, input bit ki, input bit tk);
    bit evm, evs, evi, strobe, changed, o_edit;
    int o_mode, o_field;
    evm = m_armed && m_pm && !km;
    evs = m_armed && m_ps && !ks;
    evi = m_armed && m_pi && !ki;
    o_mode = m_mode; o_field = m_field; o_edit = m_edit;
    strobe = 0; m_clr = 0; m_inc = 3'b000;
    if (evm) begin
      if (m_edit) m_edit = 0; else m_mode = (m_mode + 1) % 3;
      m_field = 0; m_held = -1;
    end else if (evs) begin
      m_held = -1;
      if (m_mode == 2) begin
        m_clr = 1; m_run = 0;
      end else if (!m_edit) begin
        m_edit = 1; m_field = 1;
      end else begin
        m_field++;
        if (m_field > ((m_mode == 0) ? 3 : 2)) begin m_edit = 0; m_field = 0; end
      end
    end else if (evi) begin
      if (m_edit) begin strobe = 1; m_held = 0; end
      else if (m_mode == 2) m_run = !m_run;
    end else begin
      if (m_held >= 0 && ki) m_held = -1;
      else if (m_held >= 0 && tk) begin
        m_held++;
        if (m_held >= DELAY && ((m_held - DELAY) % RATE) == 0) strobe = 1;
      end
      if (m_edit && !strobe && tk) begin
        m_idle++;
        if (m_idle >= TIMEOUT) begin m_edit = 0; m_field = 0; m_held = -1; end
      end
    end
    if (evm || evs || evi || strobe || !m_edit) m_idle = 0;
    if (strobe) m_inc[3 - m_field] = 1'b1;
    changed = (m_mode != o_mode) || (m_field != o_field) || (m_edit != o_edit);
    if (!m_edit || changed || strobe) m_bt = 0;
    else if (tk) m_bt++;
    m_blank = m_edit && (((m_bt / BLINK) % 2) == 1);
    m_pm = km; m_ps = ks; m_pi = ki; m_armed = 1;
  endtask

  task automatic cycle(input bit km, input bit ks, input bit ki, input bit tk);
    bus.key_mode = km; bus.key_sel = ks; bus.key_inc = ki; bus.tick_1ms = tk;
    @(posedge clk);
    model_step(km, ks, ki, tk);
    #1;
  endtask

  task automatic do_reset(input bit km);
    bus.key_mode = km; bus.key_sel = H; bus.key_inc = H; bus.tick_1ms = L;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(L);
    nvec++;
    if (w_dut !== 10'b0) begin
      nbad++; $display("FAIL reset_values: dut=%b exp=%b", w_dut, 10'b0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(L, H, H, L);
      nvec++;
      if (bus.mode !== 2'b00 || w_dut !== exp_vec()) begin
        nbad++; $display("FAIL held_through_reset: dut=%b exp=%b", w_dut, exp_vec());
      end
    end
    cycle(H, H, H, L);
    cycle(L, H, H, L);
    nvec++;
    if (bus.mode !== 2'b01 || w_dut !== exp_vec()) begin
      nbad++; $display("FAIL fresh_press_mode: mode=%b exp=01 dut=%b", bus.mode, w_dut);
    end
    cycle(H, H, H, L);
  endtask

  task automatic test_sel_walk();
    logic [1:0] t_exp[4];
    logic [1:0] a_exp[3];
    t_exp = '{2'b01, 2'b10, 2'b11, 2'b00};
    a_exp = '{2'b01, 2'b10, 2'b00};
    do_reset(H);
    cycle(H, H, H, L);
    for (int i = 0; i < 4; i++) begin
      cycle(H, L, H, L);
      nvec++;
      if (bus.edit_field !== t_exp[i] || bus.mode !== 2'b00 || w_dut !== exp_vec()) begin
        nbad++; $display("FAIL time_sel_%0d: field=%b mode=%b exp field=%b mode=00", i, bus.edit_field, bus.mode, t_exp[i]);
      end
      cycle(H, H, H, L);
    end
    cycle(L, H, H, L);
    cycle(H, H, H, L);
    for (int i = 0; i < 3; i++) begin
      cycle(H, L, H, L);
      nvec++;
      if (bus.edit_field !== a_exp[i] || bus.mode !== 2'b01 || w_dut !== exp_vec()) begin
        nbad++; $display("FAIL alarm_sel_%0d: field=%b mode=%b exp field=%b mode=01", i, bus.edit_field, bus.mode, a_exp[i]);
      end
      cycle(H, H, H, L);
    end
  endtask

  task automatic test_repeat();
    int at[$];
    int exp_at[4];
    bit last;
    exp_at = '{0, DELAY, DELAY + RATE, DELAY + 2 * RATE};
    do_reset(H);
    cycle(H, H, H, L);
    cycle(H, L, H, L);
    cycle(H, H, H, L);
    cycle(H, H, L, L);
    nvec++;
    if (bus.inc_hour !== 1'b1 || w_dut !== exp_vec()) begin
      nbad++; $display("FAIL press_strobe: dut=%b exp=%b", w_dut, exp_vec());
    end
    if (bus.inc_hour === 1'b1) at.push_back(0);
    last = bus.inc_hour;
    for (int k = 1; k <= 790; k++) begin
      cycle(H, H, L, H);
      nvec++;
      if (w_dut !== exp_vec() || (bus.inc_hour && (last || bus.blank))) begin
        nbad++; $display("FAIL repeat_tick_%0d: dut=%b exp=%b", k, w_dut, exp_vec());
      end
      if (bus.inc_hour === 1'b1) at.push_back(k);
      last = bus.inc_hour;
    end
    cycle(H, H, H, L);
    nvec++;
    if (at.size() !== 4) begin
      nbad++; $display("FAIL repeat_count: got %0d strobes, exp 4", at.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (at[i] !== exp_at[i]) begin
          nbad++; $display("FAIL repeat_at_%0d: tick=%0d exp=%0d", i, at[i], exp_at[i]);
        end
      end
    end
  endtask

  task automatic test_priority();
    do_reset(H);
    cycle(H, H, H, L);
    cycle(H, L, H, L);
    cycle(H, H, H, L);
    cycle(L, H, L, L);
    nvec++;
    if (bus.mode !== 2'b00 || bus.edit_field !== 2'b00 || bus.inc_hour !== 1'b0 ||
        w_dut !== exp_vec()) begin
      nbad++; $display("FAIL mode_over_inc: dut=%b exp=%b", w_dut, exp_vec());
    end
    cycle(H, H, H, L);
  endtask

  task automatic test_watch();
    int  ops[6];
    bit  e_run[6];
    logic [1:0] e_mode[6];
    ops    = '{2, 2, 2, 1, 2, 0};
    e_run  = '{1, 0, 1, 0, 1, 1};
    e_mode = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    do_reset(H);
    cycle(H, H, H, L);
    cycle(L, H, H, L); cycle(H, H, H, L);
    cycle(L, H, H, L); cycle(H, H, H, L);
    nvec++;
    if (bus.mode !== 2'b10) begin
      nbad++; $display("FAIL enter_watch: mode=%b exp=10", bus.mode);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(ops[i] != 0, ops[i] != 1, ops[i] != 2, L);
      nvec++;
      if (bus.sw_run !== e_run[i] || bus.mode !== e_mode[i] ||
          bus.sw_clr !== (ops[i] == 1) || w_dut !== exp_vec()) begin
        nbad++; $display("FAIL watch_step_%0d: run=%b clr=%b mode=%b exp run=%b mode=%b", i, bus.sw_run, bus.sw_clr, bus.mode, e_run[i], e_mode[i]);
      end
      cycle(H, H, H, L);
      nvec++;
      if (bus.sw_clr !== 1'b0 || w_dut !== exp_vec()) begin
        nbad++; $display("FAIL watch_release_%0d: dut=%b exp=%b", i, w_dut, exp_vec());
      end
    end
  endtask

  task automatic test_timeout();
    do_reset(H);
    cycle(H, H, H, L);
    cycle(L, H, H, L); cycle(H, H, H, L);
    cycle(H, L, H, L); cycle(H, H, H, L);
    cycle(H, L, H, L); cycle(H, H, H, L);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cycle(H, H, H, H);
      if (k == TIMEOUT - 1 || (k % 997) == 0) begin
        nvec++;
        if (w_dut !== exp_vec() || bus.edit_field !== 2'b10) begin
          nbad++; $display("FAIL timeout_wait_%0d: dut=%b exp=%b", k, w_dut, exp_vec());
        end
      end
    end
    nvec++;
    if (bus.mode !== 2'b01 || bus.edit_field !== 2'b00 || bus.blank !== 1'b0 ||
        w_dut !== exp_vec()) begin
      nbad++; $display("FAIL timeout_exit: dut=%b exp mode=01 field=00 blank=0", w_dut);
    end
  endtask

  task automatic test_async_reset();
    do_reset(H);
    cycle(H, H, H, L);
    cycle(H, L, H, L);
    cycle(H, H, H, L);
    cycle(H, H, L, L);
    for (int k = 1; k <= 520; k++) cycle(H, H, L, H);
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (w_dut !== 10'b0) begin
      nbad++; $display("FAIL async_reset: dut=%b exp=%b", w_dut, 10'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(H, H, L, H);
      nvec++;
      if (w_dut !== exp_vec()) begin
        nbad++; $display("FAIL post_reset_hold_%0d: dut=%b exp=%b", i, w_dut, exp_vec());
      end
    end
    cycle(H, H, H, L);
  endtask

  task automatic test_random();
    bit km, ks, ki, tk;
    do_reset(H);
    km = H; ks = H; ki = H;
    for (int i = 0; i < 4000; i++) begin
      km = km ^ ($urandom_range(0, 5) == 0);
      ks = ks ^ ($urandom_range(0, 5) == 0);
      ki = ki ^ ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 1) == 1);
      cycle(km, ks, ki, tk);
      nvec++;
      if (w_dut !== exp_vec()) begin
        nbad++; $display("FAIL random_%0d: dut=%b exp=%b", i, w_dut, exp_vec());
      end
    end
  endtask

  initial begin
    bus.key_mode = H; bus.key_sel = H; bus.key_inc = H; bus.tick_1ms = L;
    model_reset();
    test_reset();
    test_sel_walk();
    test_repeat();
    test_priority();
    test_watch();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
`default_nettype wire
